kernel_ctrl_multi: RTL and testbench
====================================

// Module: kernel_ctrl_multi
// PURPOSE
//  Parametrised top-level controller between an ap_start/ap_done host port and a
//  dataflow kernel. Merges the run-state register, per-argument 1-slot buffers
//  and end-channel join into one block. Unlike a pure AND-join, end tokens are
//  collected individually, so channels may complete in different cycles.
//  Adds an optional ap_continue hold mode, a latched result register and a
//  saturating run-cycle counter. Instantiated once per kernel wrapper.
// PARAMETERS
//  NUM_ARGS   4   number of start/argument channels (>=1)
//  ARG_W      8   width of each argument
//  NUM_ENDS   5   number of end channels to collect (>=1); channel 0 carries the result
//  RES_W      8   width of the result data on end channel 0
//  HOLD_DONE  0   0: DONE lasts 1 cycle then IDLE; 1: DONE holds until ap_continue
//  CNT_W      32  run-cycle counter width
// PORTS
//  clk          in   1                clock
//  rst          in   1                reset (synchronous, active-high)
//  ap_start     in   1                host start request
//  ap_continue  in   1                host acknowledge of done; used only when HOLD_DONE=1
//  ap_ready     out  1                controller idle and able to accept ap_start
//  ap_idle      out  1                state == IDLE
//  ap_done      out  1                state == DONE
//  args_in      in   NUM_ARGS*ARG_W   argument values; arg i is [i*ARG_W +: ARG_W]
//  arg_valid    out  NUM_ARGS         per-argument token valid toward the kernel
//  arg_ready    in   NUM_ARGS         per-argument ready from the kernel
//  arg_data     out  NUM_ARGS*ARG_W   latched argument values
//  end_valid    in   NUM_ENDS         per-end-channel valid from the kernel
//  end_ready    out  NUM_ENDS         per-end-channel ready toward the kernel
//  res_in       in   RES_W            data on end channel 0
//  res_out      out  RES_W            result latched on the end channel 0 handshake
//  run_cycles   out  CNT_W            number of cycles spent in RUN for the last or current call
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. Reset (any state): state=IDLE; arg_data, res_out and
//    run_cycles cleared to 0; sent and got flags cleared.
//  - Reset output values: ap_ready=1, ap_idle=1, ap_done=0, arg_valid=0, end_ready=0.
//  - IDLE: when ap_start=1, capture args_in into arg_data, clear sent[] and got[],
//    clear run_cycles, and move to RUN on the next edge. ap_ready=ap_idle=1 only in IDLE.
//  - RUN, arguments: arg_valid[i] = !sent[i].
//    - sent[i] sets on arg_valid[i] & arg_ready[i].
//    - Each argument is delivered exactly once per call; arg_data is stable throughout RUN.
//  - RUN, end channels: end_ready[i] = !got[i]; got[i] sets on the handshake.
//    - Channel 0 handshake loads res_in into res_out.
//    - A second token on a collected channel is not accepted (ready stays low).
//  - RUN exit: leave for DONE when (got | handshake_now) is all-ones AND
//    (sent | arg_handshake_now) is all-ones.
//    - If the last end handshake is in cycle t, ap_done=1 in cycle t+1.
//    - All channels may complete in the same cycle.
//  - run_cycles increments by 1 every RUN cycle and saturates at all-ones (no wrap).
//    It holds its value in DONE and IDLE until the next start.
//  - DONE: ap_done=1; arg_valid=0 and end_ready=0.
//    - HOLD_DONE=0: return to IDLE after exactly 1 cycle.
//    - HOLD_DONE=1: stay in DONE until ap_continue=1, then go to IDLE on the next edge.
//  - ap_start outside IDLE is ignored; it is not queued.
//    - ap_start held high in IDLE after DONE immediately launches the next call.
//  - ap_continue is ignored in IDLE/RUN, and in every state when HOLD_DONE=0.
//  - rst mid-RUN: abort with no ap_done; the next cycle shows IDLE outputs.
//    A token the kernel presented in the reset cycle is not captured.
// TESTING
//  1. Defaults, args=0x04030201, kernel ready always; end channels 4..0 valid in
//     cycles 3,4,5,6,7 with res_in=0x5A
//     -> ap_done pulses 1 cycle at cycle 8; res_out=0x5A; each arg handshakes once.
//  2. All 5 end_valid rise in the same cycle t
//     -> all end_ready drop at t+1; ap_done=1 at t+1; IDLE at t+2.
//  3. HOLD_DONE=1; ap_continue asserted 10 cycles after done
//     -> ap_done high 10 cycles, ap_ready=0 throughout, IDLE 1 cycle after ap_continue.
//  4. arg_ready[2] held low 6 cycles while all ends are collected
//     -> no ap_done until arg 2 handshakes; arg_valid[2] stays 1 with stable arg_data.
//  5. rst pulsed in the 3rd RUN cycle
//     -> ap_done never asserted; next cycle arg_valid=0, ap_ready=1, run_cycles=0.
//  6. CNT_W=3; kernel finishes after 12 RUN cycles
//     -> run_cycles saturates at 7; ap_start held high restarts the call with run_cycles cleared.

Source files
------------

// File: rtl/kernel_ctrl_multi.sv
// Host-side ap_start/ap_done controller for a dataflow kernel: latches arguments,
// hands each out once per call, collects end tokens individually, then reports done.
module kernel_ctrl_multi #(
    parameter int NUM_ARGS  = 4,
    parameter int ARG_W     = 8,
    parameter int NUM_ENDS  = 5,
    parameter int RES_W     = 8,
    parameter bit HOLD_DONE = 1'b0,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ap_start,
    input  logic                      ap_continue,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic [NUM_ARGS*ARG_W-1:0] args_in,
    output logic [NUM_ARGS-1:0]       arg_valid,
    input  logic [NUM_ARGS-1:0]       arg_ready,
    output logic [NUM_ARGS*ARG_W-1:0] arg_data,
    input  logic [NUM_ENDS-1:0]       end_valid,
    output logic [NUM_ENDS-1:0]       end_ready,
    input  logic [RES_W-1:0]          res_in,
    output logic [RES_W-1:0]          res_out,
    output logic [CNT_W-1:0]          run_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_ARGS-1:0] sent, arg_hs;
    logic [NUM_ENDS-1:0] got, end_hs;
    logic in_run, launch, run_exit;

    assign in_run    = (state == S_RUN);
    assign ap_idle   = (state == S_IDLE);
    assign ap_ready  = ap_idle;
    assign ap_done   = (state == S_DONE);
    assign launch    = ap_idle && ap_start;

    // Ready/valid are gated by RUN so nothing moves in IDLE or DONE.
    assign arg_valid = in_run ? ~sent : '0;
    assign end_ready = in_run ? ~got  : '0;
    assign arg_hs    = arg_valid & arg_ready;
    assign end_hs    = end_valid & end_ready;

    // Counting this cycle's handshakes lets the last token and the exit share a cycle.
    assign run_exit  = (&(got | end_hs)) && (&(sent | arg_hs));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (ap_start) state_next = S_RUN;
            S_RUN:  if (run_exit) state_next = S_DONE;
            S_DONE: if (!HOLD_DONE || ap_continue) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arg_data   <= '0;
            res_out    <= '0;
            run_cycles <= '0;
            sent       <= '0;
            got        <= '0;
        end else if (launch) begin
            arg_data   <= args_in;
            run_cycles <= '0;
            sent       <= '0;
            got        <= '0;
        end else if (in_run) begin
            sent <= sent | arg_hs;
            got  <= got | end_hs;
            if (end_hs[0]) res_out <= res_in;
            if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_kernel_ctrl_multi.sv
// Randomised scoreboard bench for kernel_ctrl_multi (default build) plus a directed
// run on a HOLD_DONE=1, CNT_W=3 build for the hold and saturation behaviour.
module tb_kernel_ctrl_multi;

    localparam int NA = 4;
    localparam int AW = 8;
    localparam int NE = 5;
    localparam int RW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, ap_start, ap_continue, ap_ready, ap_idle, ap_done;
    logic [NA*AW-1:0]  args_in, arg_data;
    logic [NA-1:0]     arg_valid, arg_ready;
    logic [NE-1:0]     end_valid, end_ready;
    logic [RW-1:0]     res_in, res_out;
    logic [31:0]       run_cycles;

    logic              b_ap_start, b_ap_continue, b_ap_ready, b_ap_idle, b_ap_done;
    logic [15:0]       b_args_in, b_arg_data;
    logic [1:0]        b_arg_valid, b_arg_ready, b_end_valid, b_end_ready;
    logic [7:0]        b_res_in, b_res_out;
    logic [2:0]        b_run_cycles;

    kernel_ctrl_multi #(.NUM_ARGS(NA), .ARG_W(AW), .NUM_ENDS(NE), .RES_W(RW),
                        .HOLD_DONE(1'b0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
        .args_in(args_in), .arg_valid(arg_valid), .arg_ready(arg_ready),
        .arg_data(arg_data), .end_valid(end_valid), .end_ready(end_ready),
        .res_in(res_in), .res_out(res_out), .run_cycles(run_cycles));

    kernel_ctrl_multi #(.NUM_ARGS(2), .ARG_W(8), .NUM_ENDS(2), .RES_W(8),
                        .HOLD_DONE(1'b1), .CNT_W(3)) dut_h (
        .clk(clk), .rst(rst), .ap_start(b_ap_start), .ap_continue(b_ap_continue),
        .ap_ready(b_ap_ready), .ap_idle(b_ap_idle), .ap_done(b_ap_done),
        .args_in(b_args_in), .arg_valid(b_arg_valid), .arg_ready(b_arg_ready),
        .arg_data(b_arg_data), .end_valid(b_end_valid), .end_ready(b_end_ready),
        .res_in(b_res_in), .res_out(b_res_out), .run_cycles(b_run_cycles));

    typedef struct {
        logic [NA*AW-1:0] args;
        logic [RW-1:0]    res;
        int               cycles;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ph = 0;              // expected phase: 0 idle, 1 run, 2 done
    logic [NA-1:0] exp_av = '0;
    logic [NE-1:0] exp_er = '0;
    int          hs_a[NA];
    int          hs_e[NE];
    bit          mon_en = 1'b0;
    int          sched_a[NA];         // RUN-cycle index at which each arg is accepted
    int          sched_e[NE];         // RUN-cycle index at which each end token appears

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle protocol model plus per-call scoreboard pop on ap_done.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ap_idle", ap_idle, ph == 0);
            check("ap_ready", ap_ready, ph == 0);
            check("ap_done", ap_done, ph == 2);
            check("arg_valid", arg_valid, exp_av);
            check("end_ready", end_ready, exp_er);
            if (ph == 1 && sbq.size() > 0) check("arg_data_stable", arg_data, sbq[0].args);
            for (int i = 0; i < NA; i++) if (arg_valid[i] && arg_ready[i]) hs_a[i]++;
            for (int j = 0; j < NE; j++) if (end_valid[j] && end_ready[j]) hs_e[j]++;
            if (ap_done) begin
                if (sbq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: ap_done with empty scoreboard at %0t", $time);
                end else begin
                    mon_e = sbq.pop_front();
                    check("res_out", res_out, mon_e.res);
                    check("run_cycles", run_cycles, mon_e.cycles);
                    for (int i = 0; i < NA; i++) begin check("arg_hs_once", hs_a[i], 1); hs_a[i] = 0; end
                    for (int j = 0; j < NE; j++) begin check("end_hs_once", hs_e[j], 1); hs_e[j] = 0; end
                end
            end
            if (rst) begin
                sbq.delete();
                for (int i = 0; i < NA; i++) hs_a[i] = 0;
                for (int j = 0; j < NE; j++) hs_e[j] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One call on the default DUT; abort_k >= 0 pulses rst in that RUN cycle.
    task automatic drive_call(input logic [NA*AW-1:0] a, input logic [RW-1:0] r,
                              input int gap, input int abort_k);
        exp_t e;
        int   m;
        repeat (gap) begin
            ph = 0; exp_av = '0; exp_er = '0; ap_start = 1'b0;
            args_in = $urandom; arg_ready = NA'($urandom); end_valid = NE'($urandom);
            ap_continue = 1'($urandom);
            tick();
        end
        m = 0;
        for (int i = 0; i < NA; i++) if (sched_a[i] > m) m = sched_a[i];
        for (int j = 0; j < NE; j++) if (sched_e[j] > m) m = sched_e[j];
        e.args = a; e.res = r; e.cycles = m + 1;
        sbq.push_back(e);
        ph = 0; exp_av = '0; exp_er = '0; ap_start = 1'b1; args_in = a;
        arg_ready = NA'($urandom); end_valid = NE'($urandom);
        tick();
        for (int k = 0; k <= m; k++) begin
            ph = 1; ap_start = 1'($urandom); args_in = $urandom; ap_continue = 1'($urandom);
            res_in = (k == sched_e[0]) ? r : RW'($urandom);
            for (int i = 0; i < NA; i++) begin
                arg_ready[i] = (k >= sched_a[i]);
                exp_av[i]    = (k <= sched_a[i]);
            end
            for (int j = 0; j < NE; j++) begin
                end_valid[j] = (k >= sched_e[j]);
                exp_er[j]    = (k <= sched_e[j]);
            end
            if (k == abort_k) begin
                rst = 1'b1; end_valid = '1; res_in = ~r;
            end
            tick();
            if (k == abort_k) begin
                rst = 1'b0; ph = 0; exp_av = '0; exp_er = '0; ap_start = 1'b0;
                check("abort_ap_ready", ap_ready, 1'b1);
                check("abort_ap_done", ap_done, 1'b0);
                check("abort_arg_valid", arg_valid, '0);
                check("abort_run_cycles", run_cycles, 0);
                check("abort_res_out", res_out, 0);
                check("abort_arg_data", arg_data, 0);
                return;
            end
        end
        ph = 2; exp_av = '0; exp_er = '0; ap_start = 1'($urandom);
        arg_ready = NA'($urandom); end_valid = NE'($urandom); ap_continue = 1'($urandom);
        tick();
        ph = 0; ap_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0; args_in = '0; arg_ready = '0;
        end_valid = '0; res_in = '0;
        b_ap_start = 1'b0; b_ap_continue = 1'b0; b_args_in = '0; b_arg_ready = '0;
        b_end_valid = '0; b_res_in = '0;
        for (int i = 0; i < NA; i++) hs_a[i] = 0;
        for (int j = 0; j < NE; j++) hs_e[j] = 0;
        tick(); tick();
        check("rst_ap_ready", ap_ready, 1'b1);
        check("rst_ap_idle", ap_idle, 1'b1);
        check("rst_ap_done", ap_done, 1'b0);
        check("rst_arg_valid", arg_valid, '0);
        check("rst_end_ready", end_ready, '0);
        check("rst_res_out", res_out, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_arg_data", arg_data, 0);
        check("rst_b_ap_ready", b_ap_ready, 1'b1);
        rst = 1'b0;
        mon_en = 1'b1;

        // Staggered end channels, kernel always ready.
        for (int i = 0; i < NA; i++) sched_a[i] = 0;
        for (int j = 0; j < NE; j++) sched_e[j] = 4 - j;
        drive_call(32'h04030201, 8'h5A, 1, -1);
        // All end channels in the same cycle.
        for (int i = 0; i < NA; i++) sched_a[i] = i % 2;
        for (int j = 0; j < NE; j++) sched_e[j] = 3;
        drive_call(32'hA1B2C3D4, 8'h3C, 0, -1);
        // Arg 2 stalls well past the last end token.
        for (int i = 0; i < NA; i++) sched_a[i] = (i == 2) ? 6 : 0;
        for (int j = 0; j < NE; j++) sched_e[j] = j % 3;
        drive_call(32'hDEADBEEF, 8'h81, 0, -1);
        // Reset in the third RUN cycle.
        for (int i = 0; i < NA; i++) sched_a[i] = 8;
        for (int j = 0; j < NE; j++) sched_e[j] = 9;
        drive_call(32'h55AA55AA, 8'h11, 1, 2);
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NA; i++) sched_a[i] = int'($urandom_range(0, 6));
            for (int j = 0; j < NE; j++) sched_e[j] = int'($urandom_range(0, 6));
            drive_call($urandom, RW'($urandom), int'($urandom_range(0, 2)), -1);
        end
        tick();
        mon_en = 1'b0;
        check("scoreboard_drained", sbq.size(), 0);

        // HOLD_DONE=1, CNT_W=3 build: 12 RUN cycles, held DONE, back-to-back restart.
        b_ap_start = 1'b1; b_args_in = 16'hBEEF; b_ap_continue = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            check("b_run_cycles_sat", b_run_cycles, (k > 7) ? 7 : k);
            check("b_no_done_in_run", b_ap_done, 1'b0);
            check("b_arg_data", b_arg_data, 16'hBEEF);
            b_args_in = 16'($urandom); b_ap_continue = 1'($urandom);
            b_arg_ready = (k >= 1) ? 2'b11 : 2'b00;
            b_end_valid = (k == 11) ? 2'b11 : 2'b00;
            b_res_in = (k == 11) ? 8'hC3 : 8'($urandom);
            tick();
        end
        for (int d = 0; d < 10; d++) begin
            check("b_done_held", b_ap_done, 1'b1);
            check("b_ready_low", b_ap_ready, 1'b0);
            check("b_run_cycles_done", b_run_cycles, 7);
            check("b_res_out", b_res_out, 8'hC3);
            b_ap_continue = (d == 9); b_end_valid = 2'($urandom);
            tick();
        end
        check("b_idle_after_cont", b_ap_idle, 1'b1);
        check("b_done_cleared", b_ap_done, 1'b0);
        check("b_run_cycles_hold", b_run_cycles, 7);
        b_args_in = 16'h1234; b_ap_continue = 1'b0; b_end_valid = 2'b00;
        tick();
        check("b_restart_cnt_clear", b_run_cycles, 0);
        check("b_restart_arg_valid", b_arg_valid, 2'b11);
        check("b_restart_arg_data", b_arg_data, 16'h1234);
        b_arg_ready = 2'b11; b_end_valid = 2'b11; b_res_in = 8'h77; b_ap_start = 1'b0;
        tick();
        check("b_done2", b_ap_done, 1'b1);
        check("b_run_cycles2", b_run_cycles, 1);
        check("b_res_out2", b_res_out, 8'h77);
        check("b_end_ready_done", b_end_ready, 2'b00);
        tick();
        check("b_done2_held", b_ap_done, 1'b1);
        b_ap_continue = 1'b1;
        tick();
        check("b_idle2", b_ap_idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
